// File: rtl/operand_stage.sv
// ID->EX operand stage: writeback bypass for both sources, load-use stall
// detection with a one-cycle bubble, flush handling and a saturating stall counter.

module operand_bypass (
  input  logic [4:0]  rs_addr,
  input  logic [31:0] rf_data,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] op
);
  // x0 wins over any bypass; since rs_addr!=0 on the bypass arm, wb_rd_addr==0 never forwards
  always_comb begin
    op = rf_data;
    if (rs_addr == 5'd0)                                op = '0;
    else if (wb_regwrite && (wb_rd_addr == rs_addr))    op = wb_data;
  end
endmodule

module operand_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic [31:0] rf_rs1,
  input  logic [31:0] rf_rs2,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_data,
  input  logic        ex_flush,
  output logic        id_stall,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic [4:0]  ex_rs1_addr,
  output logic [4:0]  ex_rs2_addr,
  output logic [4:0]  ex_rd_addr,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [15:0] stall_count
);
  localparam int NUM_OPS = 2;

  typedef enum logic {RUN, BUBBLE} state_t;

  state_t      state_q;
  logic        valid_q, regwrite_q, memread_q;
  logic [4:0]  rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [31:0] rs1_data_q, rs2_data_q;
  logic [15:0] stall_cnt_q;

  logic [NUM_OPS-1:0][4:0]  rs_addr;
  logic [NUM_OPS-1:0][31:0] rf_data;
  logic [NUM_OPS-1:0][31:0] op;
  logic                     hazard;

  assign rs_addr = {id_rs2_addr, id_rs1_addr};
  assign rf_data = {rf_rs2, rf_rs1};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_byp
    operand_bypass u_byp (
      .rs_addr     (rs_addr[g]),
      .rf_data     (rf_data[g]),
      .wb_regwrite (wb_regwrite),
      .wb_rd_addr  (wb_rd_addr),
      .wb_data     (wb_data),
      .op          (op[g])
    );
  end

  // BUBBLE gating is redundant with the cleared memread but makes the 1-cycle stall explicit
  assign hazard = (state_q == RUN) && id_valid && valid_q && memread_q &&
                  (rd_addr_q != 5'd0) &&
                  ((rd_addr_q == id_rs1_addr) || (rd_addr_q == id_rs2_addr));
  assign id_stall = hazard && !ex_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      stall_cnt_q <= '0;
    end else if (ex_flush || id_stall) begin
      state_q     <= ex_flush ? RUN : BUBBLE;
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      if (!ex_flush && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end else begin
      state_q     <= RUN;
      valid_q     <= id_valid;
      regwrite_q  <= id_valid && id_regwrite;
      memread_q   <= id_valid && id_memread;
      rs1_addr_q  <= id_rs1_addr;
      rs2_addr_q  <= id_rs2_addr;
      rd_addr_q   <= id_rd_addr;
      rs1_data_q  <= op[0];
      rs2_data_q  <= op[1];
    end
  end

  assign ex_valid    = valid_q;
  assign ex_regwrite = regwrite_q;
  assign ex_memread  = memread_q;
  assign ex_rs1_addr = rs1_addr_q;
  assign ex_rs2_addr = rs2_addr_q;
  assign ex_rd_addr  = rd_addr_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign stall_count = stall_cnt_q;
endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: bypass, x0, load-use stall, flush, saturation, async reset.

module tb_operand_stage;
  logic        clk, rst;
  logic        id_valid, id_regwrite, id_memread;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] rf_rs1, rf_rs2;
  logic        wb_regwrite;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        ex_flush;
  logic        id_stall, ex_valid, ex_regwrite, ex_memread;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [31:0] ex_rs1_data, ex_rs2_data;
  logic [15:0] stall_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  operand_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .wb_regwrite(wb_regwrite), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .ex_flush(ex_flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    id_valid = 0; id_regwrite = 0; id_memread = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    rf_rs1 = 0; rf_rs2 = 0;
    wb_regwrite = 0; wb_rd_addr = 0; wb_data = 0;
    ex_flush = 0;
  endtask

  task automatic drive_lw7;
    clear_inputs();
    id_valid = 1; id_memread = 1; id_regwrite = 1;
    id_rs1_addr = 5'd2; id_rd_addr = 5'd7;
  endtask

  task automatic drive_use7;
    clear_inputs();
    id_valid = 1; id_regwrite = 1;
    id_rs1_addr = 5'd3; id_rs2_addr = 5'd7; id_rd_addr = 5'd8;
    rf_rs1 = 32'h33; rf_rs2 = 32'h77;
  endtask

  task automatic test_reset;
    rst = 0;
    clear_inputs();
    id_valid = 1; id_rd_addr = 5'd9; id_regwrite = 1;
    tick(); tick();
    total_cnt++;
    if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid got %0b want 0", ex_valid); else pass_cnt++;
    total_cnt++;
    if (ex_rd_addr !== 5'd0 || ex_regwrite !== 1'b0)
      $display("FAIL reset_ex_rd got %0d/%0b want 0/0", ex_rd_addr, ex_regwrite); else pass_cnt++;
    total_cnt++;
    if (stall_count !== 16'd0) $display("FAIL reset_stall_count got %0h want 0", stall_count); else pass_cnt++;
    total_cnt++;
    if (id_stall !== 1'b0) $display("FAIL reset_id_stall got %0b want 0", id_stall); else pass_cnt++;
    rst = 1;
    clear_inputs();
    tick();
  endtask

  task automatic test_bypass;
    clear_inputs();
    id_valid = 1; id_regwrite = 1; id_rd_addr = 5'd9;
    id_rs1_addr = 5'd5; rf_rs1 = 32'h11; id_rs2_addr = 5'd6; rf_rs2 = 32'h22;
    wb_regwrite = 1; wb_rd_addr = 5'd5; wb_data = 32'hAA;
    tick();
    total_cnt++;
    if (ex_rs1_data !== 32'hAA) $display("FAIL bypass_rs1 got %0h want aa", ex_rs1_data); else pass_cnt++;
    total_cnt++;
    if (ex_rs2_data !== 32'h22) $display("FAIL bypass_rs2_nomatch got %0h want 22", ex_rs2_data); else pass_cnt++;
    total_cnt++;
    if (ex_valid !== 1'b1 || ex_regwrite !== 1'b1 || ex_rd_addr !== 5'd9 || ex_rs1_addr !== 5'd5)
      $display("FAIL capture_ctrl got v=%0b rw=%0b rd=%0d rs1=%0d want 1 1 9 5",
               ex_valid, ex_regwrite, ex_rd_addr, ex_rs1_addr); else pass_cnt++;
    wb_rd_addr = 5'd0;
    tick();
    total_cnt++;
    if (ex_rs1_data !== 32'h11) $display("FAIL bypass_wbrd0 got %0h want 11", ex_rs1_data); else pass_cnt++;
    wb_rd_addr = 5'd5; wb_regwrite = 0;
    tick();
    total_cnt++;
    if (ex_rs1_data !== 32'h11) $display("FAIL bypass_wbdisabled got %0h want 11", ex_rs1_data); else pass_cnt++;
    wb_regwrite = 1; wb_rd_addr = 5'd6; wb_data = 32'hBEEF;
    tick();
    total_cnt++;
    if (ex_rs2_data !== 32'hBEEF || ex_rs1_data !== 32'h11)
      $display("FAIL bypass_rs2 got %0h/%0h want beef/11", ex_rs2_data, ex_rs1_data); else pass_cnt++;
  endtask

  task automatic test_x0_and_invalid;
    clear_inputs();
    id_valid = 1; id_rs1_addr = 5'd0; rf_rs1 = 32'h1234;
    wb_regwrite = 1; wb_rd_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    tick();
    total_cnt++;
    if (ex_rs1_data !== 32'h0) $display("FAIL x0_operand got %0h want 0", ex_rs1_data); else pass_cnt++;
    clear_inputs();
    id_valid = 0; id_regwrite = 1; id_memread = 1; id_rd_addr = 5'd4; id_rs1_addr = 5'd4;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0 || ex_rd_addr !== 5'd4)
      $display("FAIL invalid_capture got v=%0b rw=%0b mr=%0b rd=%0d want 0 0 0 4",
               ex_valid, ex_regwrite, ex_memread, ex_rd_addr); else pass_cnt++;
    // an invalid load in EX must not stall a dependent instruction
    id_valid = 1; id_memread = 0;
    #1;
    total_cnt++;
    if (id_stall !== 1'b0) $display("FAIL invalid_load_no_stall got %0b want 0", id_stall); else pass_cnt++;
    tick();
  endtask

  task automatic test_load_use;
    drive_lw7();
    tick();
    drive_use7();
    #1;
    total_cnt++;
    if (id_stall !== 1'b1) $display("FAIL loaduse_stall got %0b want 1", id_stall); else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b0 || ex_rd_addr !== 5'd0 || ex_rs2_data !== 32'h0)
      $display("FAIL loaduse_bubble got v=%0b rd=%0d d2=%0h want 0 0 0",
               ex_valid, ex_rd_addr, ex_rs2_data); else pass_cnt++;
    total_cnt++;
    if (stall_count !== 16'd1) $display("FAIL loaduse_count got %0h want 1", stall_count); else pass_cnt++;
    total_cnt++;
    if (id_stall !== 1'b0) $display("FAIL loaduse_release got %0b want 0", id_stall); else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b1 || ex_rd_addr !== 5'd8 || ex_rs2_addr !== 5'd7 || ex_rs2_data !== 32'h77)
      $display("FAIL loaduse_capture got v=%0b rd=%0d rs2=%0d d2=%0h want 1 8 7 77",
               ex_valid, ex_rd_addr, ex_rs2_addr, ex_rs2_data); else pass_cnt++;
    // writeback to the same register does not cancel the load-use stall
    drive_lw7();
    tick();
    drive_use7();
    wb_regwrite = 1; wb_rd_addr = 5'd7; wb_data = 32'hCAFE;
    #1;
    total_cnt++;
    if (id_stall !== 1'b1) $display("FAIL wb_and_hazard_stall got %0b want 1", id_stall); else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (stall_count !== 16'd2 || ex_rs2_data !== 32'hCAFE)
      $display("FAIL wb_and_hazard_result got cnt=%0h d2=%0h want 2 cafe", stall_count, ex_rs2_data);
    else pass_cnt++;
    // load to x0 never stalls
    drive_lw7(); id_rd_addr = 5'd0;
    tick();
    drive_use7(); id_rs2_addr = 5'd0;
    #1;
    total_cnt++;
    if (id_stall !== 1'b0) $display("FAIL load_x0_no_stall got %0b want 0", id_stall); else pass_cnt++;
    tick();
  endtask

  task automatic test_flush;
    drive_lw7();
    tick();
    drive_use7();
    ex_flush = 1;
    #1;
    total_cnt++;
    if (id_stall !== 1'b0) $display("FAIL flush_stall got %0b want 0", id_stall); else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b0 || ex_rd_addr !== 5'd0 || ex_rs2_addr !== 5'd0 || ex_rs1_data !== 32'h0 || ex_regwrite !== 1'b0)
      $display("FAIL flush_bubble got v=%0b rd=%0d rs2=%0d d1=%0h rw=%0b want all 0",
               ex_valid, ex_rd_addr, ex_rs2_addr, ex_rs1_data, ex_regwrite); else pass_cnt++;
    total_cnt++;
    if (stall_count !== 16'd2) $display("FAIL flush_count got %0h want 2", stall_count); else pass_cnt++;
    ex_flush = 0;
    tick();
  endtask

  task automatic test_saturate;
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    #1;
    total_cnt++;
    if (stall_count !== 16'hFFFE) $display("FAIL sat_preload got %0h want fffe", stall_count); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      drive_lw7();
      tick();
      drive_use7();
      tick();
      total_cnt++;
      if (stall_count !== 16'hFFFF) $display("FAIL sat_count_%0d got %0h want ffff", i, stall_count);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_reset_mid_stall;
    drive_lw7();
    tick();
    drive_use7();
    #1;
    total_cnt++;
    if (id_stall !== 1'b1) $display("FAIL rst_pre_stall got %0b want 1", id_stall); else pass_cnt++;
    rst = 0;
    #1;
    total_cnt++;
    if (ex_valid !== 1'b0 || ex_memread !== 1'b0 || ex_rd_addr !== 5'd0 || ex_rs1_data !== 32'h0)
      $display("FAIL rst_async_ex got v=%0b mr=%0b rd=%0d d1=%0h want all 0",
               ex_valid, ex_memread, ex_rd_addr, ex_rs1_data); else pass_cnt++;
    total_cnt++;
    if (stall_count !== 16'd0) $display("FAIL rst_async_count got %0h want 0", stall_count); else pass_cnt++;
    total_cnt++;
    if (id_stall !== 1'b0) $display("FAIL rst_async_stall got %0b want 0", id_stall); else pass_cnt++;
    #1;
    rst = 1;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b1 || ex_rd_addr !== 5'd8 || ex_rs1_data !== 32'h33)
      $display("FAIL rst_then_capture got v=%0b rd=%0d d1=%0h want 1 8 33",
               ex_valid, ex_rd_addr, ex_rs1_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_x0_and_invalid();
    test_load_use();
    test_flush();
    test_saturate();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-003 SHALL have port id_valid  input  1  decode stage holds a valid instruction.
REQ-004 SHALL have ports id_rs1_addr, id_rs2_addr, id_rd_addr  input  5 each  decoded source and destination register indices.
REQ-005 SHALL have ports id_regwrite, id_memread  input  1 each  decoded control: writes rd / is a load.
REQ-006 SHALL have ports rf_rs1, rf_rs2  input  32 each  register-file read data for id_rs1_addr / id_rs2_addr.
REQ-007 SHALL have ports wb_regwrite  input  1, wb_rd_addr  input  5, wb_data  input  32  writeback bus, identical to the register-file write port this cycle.
REQ-008 SHALL have port ex_flush  input  1  taken-branch flush from EX.
REQ-009 SHALL have port id_stall  output  1  hold PC and IF/ID register this cycle.
REQ-010 SHALL have ports ex_valid, ex_regwrite, ex_memread  output  1 each  registered ID/EX control.
REQ-011 SHALL have ports ex_rs1_addr, ex_rs2_addr, ex_rd_addr  output  5 each  registered ID/EX register indices.
REQ-012 SHALL have ports ex_rs1_data, ex_rs2_data  output  32 each  registered ID/EX operands.
REQ-013 SHALL have port stall_count  output  16  saturating count of load-use bubbles inserted.

Function
REQ-014 SHALL compute bypassed operand op1 = 0 if id_rs1_addr==0; else wb_data if wb_regwrite && wb_rd_addr==id_rs1_addr; else rf_rs1 (register file does not show same-cycle writes).
REQ-015 SHALL compute op2 identically from id_rs2_addr / rf_rs2.
REQ-016 SHALL detect load-use hazard = id_valid && ex_valid && ex_memread && ex_rd_addr!=0 && (ex_rd_addr==id_rs1_addr || ex_rd_addr==id_rs2_addr).
REQ-017 SHALL drive id_stall = hazard && !ex_flush, combinationally, same cycle.
REQ-018 SHALL, on a clock edge with ex_flush=1, load a bubble: ex_valid, ex_regwrite, ex_memread, all ex_*_addr and ex_*_data to 0; flush has priority over stall and normal capture.
REQ-019 SHALL, on a clock edge with id_stall=1, load the same bubble and increment stall_count.
REQ-020 SHALL, otherwise, capture ex_valid<=id_valid, addresses, op1, op2 and control; when id_valid=0, ex_regwrite and ex_memread SHALL be captured as 0.
REQ-021 SHALL implement a two-state controller RUN/BUBBLE: RUN->BUBBLE on a stall edge; BUBBLE->RUN unconditionally next edge; a hazard cannot persist into BUBBLE because the inserted bubble clears ex_memread, so stall length is exactly 1 cycle per load.
REQ-022 SHALL saturate stall_count at 16'hFFFF (no wrap); flush-only bubbles SHALL NOT count.
REQ-023 SHALL have latency of 1 cycle from ID inputs to ex_* outputs; no combinational path from ID inputs to ex_* outputs.
REQ-024 SHALL treat wb_rd_addr==0 writes as no bypass; simultaneous WB bypass and load-use hazard on the same register SHALL still stall.

Reset
REQ-025 SHALL, while rst=0, asynchronously force all ex_* outputs, stall_count and controller state (RUN) to 0, independent of clk.
REQ-026 SHALL, on rst asserted mid-stall, drop id_stall to 0 via ex_valid=0; first edge after deassertion performs normal capture.

Verification
REQ-027 SHALL pass: rs1=x5, rf_rs1=0x11, wb_regwrite=1, wb_rd=5, wb_data=0xAA -> next edge ex_rs1_data=0xAA; with wb_rd=0 -> 0x11.
REQ-028 SHALL pass: ex holds lw x7 (ex_memread=1, ex_rd=7), id rs2=x7 -> id_stall=1 that cycle, next edge ex_valid=0, stall_count=1, following cycle id_stall=0 and instruction captured.
REQ-029 SHALL pass: same hazard with ex_flush=1 -> id_stall=0, bubble loaded, stall_count unchanged.
REQ-030 SHALL pass: id rs1=x0 with wb_rd=0, wb_data=0xFFFFFFFF, rf_rs1=0x1234 -> ex_rs1_data=0.
REQ-031 SHALL pass: preload stall_count=0xFFFE, force 3 load-use stalls -> stall_count=0xFFFF.
REQ-032 SHALL pass: assert rst between edges during stall -> all ex_* and stall_count 0 immediately, id_stall=0.
